c_raddr_sched: RTL and testbench

//  Read-address scheduler for the conv input read mux. Takes one layer-tile command and emits the
//  KxK sliding-window read-address stream (m_addr/first/last/valid) plus the rinfo routing word.

---
 rtl/c_raddr_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_c_raddr_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_raddr_sched.sv
// c_raddr_sched: KxK sliding-window read-address scheduler for the conv read mux.
// Walks oy/ox/ky/kx with adders only and throttles on windows still in flight.
module c_raddr_sched #(
    parameter int AW     = 14,
    parameter int IMW    = 7,
    parameter int MAX_OS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [AW-1:0]  cmd_base,
    input  logic [IMW-1:0] cmd_width,
    input  logic [IMW-1:0] cmd_ow,
    input  logic [IMW-1:0] cmd_oh,
    input  logic [1:0]     cmd_k,
    input  logic           cmd_stride,
    input  logic           cmd_mem_sel,
    input  logic           cmd_ram_sel,
    input  logic [2:0]     cmd_channel,
    output logic [AW-1:0]  m_addr,
    output logic           m_addr_first,
    output logic           m_addr_last,
    output logic           m_addr_valid,
    input  logic           m_addr_ready,
    output logic [6:0]     rinfo,
    input  logic           d_last_hs,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW-1:0]  ONE_A    = 1;
    localparam logic [IMW-1:0] ONE_I    = 1;
    localparam logic [3:0]     MAX_OS_C = 4'(MAX_OS);

    state_t         state;
    logic [IMW-1:0] ow_r;
    logic [IMW-1:0] oh_r;
    logic [IMW-1:0] ox;
    logic [IMW-1:0] oy;
    logic [1:0]     km1;
    logic [1:0]     kx;
    logic [1:0]     ky;
    logic           s_r;
    logic [AW-1:0]  w_r;
    logic [AW-1:0]  row_step;
    logic [AW-1:0]  col_step;
    logic [AW-1:0]  oy_base;
    logic [AW-1:0]  win_base;
    logic [AW-1:0]  row_base;
    logic [3:0]     outstanding;

    logic           hs;
    logic           inc;
    logic           dec;
    logic [3:0]     out_nxt;
    logic           can_open;
    logic           kx_end;
    logic           ky_end;
    logic           ox_end;
    logic           oy_end;
    logic [1:0]     cmd_km1;
    logic [AW-1:0]  cmd_w_ext;
    logic [AW-1:0]  nxt_ky_row;
    logic [AW-1:0]  nxt_ox_win;
    logic [AW-1:0]  nxt_oy_row;

    assign hs         = m_addr_valid & m_addr_ready;
    assign inc        = hs & m_addr_last;
    assign dec        = d_last_hs & (outstanding != 4'd0);
    assign out_nxt    = outstanding + {3'b000, inc} - {3'b000, dec};
    assign can_open   = out_nxt < MAX_OS_C;

    assign kx_end     = kx == km1;
    assign ky_end     = ky == km1;
    assign ox_end     = ox == ow_r - ONE_I;
    assign oy_end     = oy == oh_r - ONE_I;

    assign cmd_km1    = (cmd_k == 2'd0) ? 2'd0 : cmd_k - 2'd1;
    assign cmd_w_ext  = AW'(cmd_width);
    assign col_step   = s_r ? (ONE_A << 1) : ONE_A;

    assign nxt_ky_row = row_base + w_r;
    assign nxt_ox_win = win_base + col_step;
    assign nxt_oy_row = oy_base + row_step;

    // Windows issued but not yet returned; a stray return at zero is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 4'd0;
        end else begin
            outstanding <= out_nxt;
        end
    end

    // Control FSM and address walker; every output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            rinfo        <= 7'd0;
            m_addr       <= '0;
            m_addr_first <= 1'b0;
            m_addr_last  <= 1'b0;
            m_addr_valid <= 1'b0;
            ow_r         <= '0;
            oh_r         <= '0;
            ox           <= '0;
            oy           <= '0;
            km1          <= 2'd0;
            kx           <= 2'd0;
            ky           <= 2'd0;
            s_r          <= 1'b0;
            w_r          <= '0;
            row_step     <= '0;
            oy_base      <= '0;
            win_base     <= '0;
            row_base     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        rinfo        <= {cmd_channel, cmd_mem_sel,
                                         cmd_ram_sel, 2'b00};
                        ow_r         <= cmd_ow;
                        oh_r         <= cmd_oh;
                        km1          <= cmd_km1;
                        s_r          <= cmd_stride;
                        w_r          <= cmd_w_ext;
                        row_step     <= cmd_stride ? (cmd_w_ext << 1)
                                                   : cmd_w_ext;
                        ox           <= '0;
                        oy           <= '0;
                        kx           <= 2'd0;
                        ky           <= 2'd0;
                        oy_base      <= cmd_base;
                        win_base     <= cmd_base;
                        row_base     <= cmd_base;
                        m_addr       <= cmd_base;
                        m_addr_first <= 1'b1;
                        m_addr_last  <= cmd_km1 == 2'd0;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        if (cmd_ow == '0 || cmd_oh == '0) begin
                            state <= DRAIN;
                        end else begin
                            state        <= RUN;
                            m_addr_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (!kx_end) begin
                            kx           <= kx + 2'd1;
                            m_addr       <= m_addr + ONE_A;
                            m_addr_first <= 1'b0;
                            m_addr_last  <= ky_end && (kx + 2'd1 == km1);
                        end else if (!ky_end) begin
                            kx           <= 2'd0;
                            ky           <= ky + 2'd1;
                            row_base     <= nxt_ky_row;
                            m_addr       <= nxt_ky_row;
                            m_addr_first <= 1'b0;
                            m_addr_last  <= 1'b0;
                        end else begin
                            kx           <= 2'd0;
                            ky           <= 2'd0;
                            m_addr_first <= 1'b1;
                            m_addr_last  <= km1 == 2'd0;
                            if (!ox_end) begin
                                ox           <= ox + ONE_I;
                                win_base     <= nxt_ox_win;
                                row_base     <= nxt_ox_win;
                                m_addr       <= nxt_ox_win;
                                m_addr_valid <= can_open;
                            end else if (!oy_end) begin
                                ox           <= '0;
                                oy           <= oy + ONE_I;
                                oy_base      <= nxt_oy_row;
                                win_base     <= nxt_oy_row;
                                row_base     <= nxt_oy_row;
                                m_addr       <= nxt_oy_row;
                                m_addr_valid <= can_open;
                            end else begin
                                m_addr_first <= 1'b0;
                                m_addr_last  <= 1'b0;
                                m_addr_valid <= 1'b0;
                                state        <= DRAIN;
                            end
                        end
                    end else if (!m_addr_valid && can_open) begin
                        m_addr_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (outstanding == 4'd0) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c_raddr_sched.sv
// tb_c_raddr_sched: vector table, corner sequences and random commands
// checked against a nested-loop address model and a window counter.
module tb_c_raddr_sched;

    localparam int AW     = 14;
    localparam int IMW    = 7;
    localparam int MAX_OS = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [AW-1:0]  cmd_base = '0;
    logic [IMW-1:0] cmd_width = '0;
    logic [IMW-1:0] cmd_ow = '0;
    logic [IMW-1:0] cmd_oh = '0;
    logic [1:0]     cmd_k = '0;
    logic           cmd_stride = 1'b0;
    logic           cmd_mem_sel = 1'b0;
    logic           cmd_ram_sel = 1'b0;
    logic [2:0]     cmd_channel = '0;
    logic [AW-1:0]  m_addr;
    logic           m_addr_first;
    logic           m_addr_last;
    logic           m_addr_valid;
    logic           m_addr_ready = 1'b0;
    logic [6:0]     rinfo;
    logic           d_last_hs = 1'b0;
    logic           busy;
    logic           done;

    c_raddr_sched #(.AW(AW), .IMW(IMW), .MAX_OS(MAX_OS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_width(cmd_width),
        .cmd_ow(cmd_ow), .cmd_oh(cmd_oh), .cmd_k(cmd_k),
        .cmd_stride(cmd_stride), .cmd_mem_sel(cmd_mem_sel),
        .cmd_ram_sel(cmd_ram_sel), .cmd_channel(cmd_channel),
        .m_addr(m_addr), .m_addr_first(m_addr_first),
        .m_addr_last(m_addr_last), .m_addr_valid(m_addr_valid),
        .m_addr_ready(m_addr_ready), .rinfo(rinfo),
        .d_last_hs(d_last_hs), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        bit            first;
        bit            last;
    } beat_t;

    typedef struct {
        string         name;
        logic [AW-1:0] base;
        int            w;
        int            ow;
        int            oh;
        int            k;
        int            s;
        int            rdy;
        bit            gap_chk;
        int            n;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] a3;
        logic [AW-1:0] alast;
    } vec_t;

    beat_t         exp_q[$];
    logic [AW-1:0] hs_addr[$];
    logic [AW-1:0] t1_hs[$];
    vec_t          tv[6];

    int            n_chk = 0;
    int            n_fail = 0;
    int            os_m = 0;
    int            win_total = 0;
    int            win_ret = 0;
    int            beats = 0;
    int            gaps = 0;
    int            done_cnt = 0;
    int            ready_pct = 100;
    int            ret_pct = 100;
    bit            ret_en = 1'b1;
    bit            force_ret = 1'b0;
    bit            seen_valid = 1'b0;
    bit            done_seen = 1'b0;
    bit            prev_valid = 1'b0;
    bit            prev_hs = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic          prev_first = 1'b0;
    logic          prev_last = 1'b0;
    logic [6:0]    exp_rinfo = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, check, drive ready/return, update model.
    task automatic step();
        bit    rdy;
        bit    dl;
        bit    hs;
        bit    lst;
        int    os_before;
        beat_t b;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (prev_valid && !prev_hs) begin
            chk("hold_valid", m_addr_valid, 1);
            chk("hold_addr", m_addr, prev_addr);
            chk("hold_first", m_addr_first, prev_first);
            chk("hold_last", m_addr_last, prev_last);
        end
        if (m_addr_valid && m_addr_first)
            chk("throttle", os_m < MAX_OS, 1);
        if (m_addr_valid) seen_valid = 1'b1;
        else if (seen_valid && exp_q.size() > 0) gaps++;
        if (done) begin
            done_cnt++;
            done_seen = 1'b1;
            chk("done_q_empty", exp_q.size(), 0);
            chk("done_os", os_m, 0);
            chk("done_ret", win_ret, win_total);
        end
        rdy = $urandom_range(99) < ready_pct;
        dl  = force_ret ||
              (ret_en && ($urandom_range(99) < ret_pct) &&
               (os_m > 0 || $urandom_range(7) == 0));
        m_addr_ready = rdy;
        d_last_hs    = dl;
        hs  = m_addr_valid && rdy;
        lst = 1'b0;
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                b = exp_q.pop_front();
                chk("addr", m_addr, b.addr);
                chk("first", m_addr_first, b.first);
                chk("last", m_addr_last, b.last);
                lst = b.last;
            end
            beats++;
            hs_addr.push_back(m_addr);
        end
        os_before = os_m;
        if (hs && lst) os_m++;
        if (dl && os_before > 0) begin
            os_m--;
            win_ret++;
        end
        prev_valid = m_addr_valid;
        prev_hs    = hs;
        prev_addr  = m_addr;
        prev_first = m_addr_first;
        prev_last  = m_addr_last;
    endtask

    // Build the expected beat list, then hand the command over.
    task automatic send_cmd(input logic [AW-1:0] base, input int w,
                            input int ow, input int oh, input int k,
                            input int s);
        int         keff;
        int         sv;
        beat_t      b;
        logic [2:0] ch;
        bit         ms;
        bit         rs;
        keff = (k == 0) ? 1 : k;
        sv   = s ? 2 : 1;
        exp_q.delete();
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < keff; ky++)
                    for (int kx = 0; kx < keff; kx++) begin
                        b.addr  = AW'(int'(base) + (oy * sv + ky) * w
                                      + ox * sv + kx);
                        b.first = (ky == 0) && (kx == 0);
                        b.last  = (ky == keff - 1) && (kx == keff - 1);
                        exp_q.push_back(b);
                    end
        ch = 3'($urandom_range(7));
        ms = 1'($urandom_range(1));
        rs = 1'($urandom_range(1));
        exp_rinfo  = {ch, ms, rs, 2'b00};
        win_total  = ow * oh;
        win_ret    = 0;
        beats      = 0;
        gaps       = 0;
        done_cnt   = 0;
        seen_valid = 1'b0;
        done_seen  = 1'b0;
        hs_addr.delete();
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_base     = base;
        cmd_width    = IMW'(w);
        cmd_ow       = IMW'(ow);
        cmd_oh       = IMW'(oh);
        cmd_k        = 2'(k);
        cmd_stride   = 1'(s);
        cmd_mem_sel  = ms;
        cmd_ram_sel  = rs;
        cmd_channel  = ch;
        cmd_valid    = 1'b1;
        m_addr_ready = 1'b0;
        d_last_hs    = 1'b0;
        prev_valid   = 1'b0;
        prev_hs      = 1'b0;
        step();
        chk("busy_after_cmd", busy, 1);
        chk("cmd_ready_busy", cmd_ready, 0);
        chk("rinfo", rinfo, exp_rinfo);
        chk("first_valid", m_addr_valid, (ow > 0) && (oh > 0));
    endtask

    task automatic run_done(input int budget);
        int n;
        n = 0;
        while (!done_seen && n < budget) begin
            step();
            n++;
        end
        chk("done_timeout", done_seen, 1);
        step();
        chk("done_pulse", done, 0);
        chk("done_count", done_cnt, 1);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{"T1", 14'h100, 4, 2, 2, 3, 0, 100, 1'b1, 36,
                  14'h100, 14'h101, 14'h102, 14'h104, 14'h10F};
        tv[1] = '{"T2", 14'h000, 8, 2, 1, 2, 1, 100, 1'b1, 8,
                  14'h000, 14'h001, 14'h008, 14'h009, 14'h00B};
        tv[2] = '{"T3", 14'h100, 4, 2, 2, 3, 0, 50, 1'b0, 36,
                  14'h100, 14'h101, 14'h102, 14'h104, 14'h10F};
        tv[3] = '{"T7", 14'h3FFE, 4, 1, 1, 2, 0, 100, 1'b1, 4,
                  14'h3FFE, 14'h3FFF, 14'h002, 14'h003, 14'h003};
        tv[4] = '{"K0S2", 14'h020, 10, 3, 2, 0, 1, 100, 1'b0, 6,
                  14'h020, 14'h022, 14'h024, 14'h034, 14'h038};
        tv[5] = '{"K2OH2", 14'h010, 5, 1, 2, 2, 0, 70, 1'b0, 8,
                  14'h010, 14'h011, 14'h015, 14'h016, 14'h01B};

        #12;
        chk("rst_valid", m_addr_valid, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_first", m_addr_first, 0);
        chk("rst_last", m_addr_last, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rinfo", rinfo, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            ready_pct = tv[i].rdy;
            ret_en    = 1'b1;
            ret_pct   = 100;
            send_cmd(tv[i].base, tv[i].w, tv[i].ow, tv[i].oh,
                     tv[i].k, tv[i].s);
            run_done(2000);
            chk({tv[i].name, "_beats"}, beats, tv[i].n);
            if (hs_addr.size() >= 4) begin
                chk({tv[i].name, "_a0"}, hs_addr[0], tv[i].a0);
                chk({tv[i].name, "_a1"}, hs_addr[1], tv[i].a1);
                chk({tv[i].name, "_a2"}, hs_addr[2], tv[i].a2);
                chk({tv[i].name, "_a3"}, hs_addr[3], tv[i].a3);
                chk({tv[i].name, "_alast"}, hs_addr[$], tv[i].alast);
            end else begin
                chk({tv[i].name, "_short"}, hs_addr.size(), 4);
            end
            if (tv[i].gap_chk) chk({tv[i].name, "_gaps"}, gaps, 0);
            if (i == 0) t1_hs = hs_addr;
        end
        if (t1_hs.size() == 36) begin
            chk("T1_win1", t1_hs[9], 14'h101);
            chk("T1_win2", t1_hs[18], 14'h104);
            chk("T1_win3", t1_hs[27], 14'h105);
        end else begin
            chk("T1_size", t1_hs.size(), 36);
        end

        // Throttle: returns withheld, four windows then stall.
        ready_pct = 100;
        ret_en    = 1'b0;
        send_cmd(14'h200, 8, 3, 2, 3, 0);
        repeat (60) step();
        chk("T4_beats_stall", beats, 36);
        chk("T4_valid_low", m_addr_valid, 0);
        chk("T4_no_done", done_cnt, 0);
        chk("T4_busy", busy, 1);
        force_ret = 1'b1;
        step();
        force_ret = 1'b0;
        step();
        chk("T4_release_valid", m_addr_valid, 1);
        chk("T4_release_first", m_addr_first, 1);
        repeat (30) step();
        chk("T4_beats_stall2", beats, 45);
        chk("T4_valid_low2", m_addr_valid, 0);
        ret_en  = 1'b1;
        ret_pct = 100;
        run_done(500);
        chk("T4_beats_total", beats, 54);

        // Empty output map: accepted, no beats, done two cycles later.
        send_cmd(14'h123, 4, 0, 3, 3, 0);
        chk("T5_done_early", done, 0);
        step();
        chk("T5_done", done, 1);
        step();
        chk("T5_done_drop", done, 0);
        chk("T5_ready", cmd_ready, 1);
        chk("T5_beats", beats, 0);

        // Asynchronous reset in the middle of a window.
        send_cmd(14'h400, 6, 2, 2, 3, 1);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("T6_valid", m_addr_valid, 0);
        chk("T6_addr", m_addr, 0);
        chk("T6_flags", {m_addr_first, m_addr_last}, 0);
        chk("T6_ready", cmd_ready, 1);
        chk("T6_busy", busy, 0);
        chk("T6_done", done, 0);
        chk("T6_rinfo", rinfo, 0);
        exp_q.delete();
        os_m       = 0;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_cmd(14'h555, 5, 1, 1, 2, 0);
        run_done(200);
        chk("T6_beats", beats, 4);
        if (hs_addr.size() > 0) chk("T6_restart", hs_addr[0], 14'h555);
        else chk("T6_restart_none", 0, 1);

        // Random commands against the model.
        repeat (12) begin
            int w;
            int ow;
            int oh;
            int k;
            int keff;
            ready_pct = $urandom_range(100, 30);
            ret_pct   = $urandom_range(90, 20);
            ret_en    = 1'b1;
            w  = $urandom_range(20);
            ow = $urandom_range(4);
            oh = $urandom_range(3);
            k  = $urandom_range(3);
            keff = (k == 0) ? 1 : k;
            send_cmd(AW'($urandom), w, ow, oh, k, $urandom_range(1));
            run_done(4000);
            chk("rand_beats", beats, ow * oh * keff * keff);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
